// File: rtl/coin_input_conditioner.sv
// Debounces the Rs5/Rs10 coin sensors into single-cycle coin codes with FIFO buffering and an idle gap.
// A steady insert is popped at edge DEBOUNCE_CYCLES+2. There is no backpressure: a push into a full FIFO is dropped and flagged.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin5_raw,
  input  logic                          coin10_raw,
  output logic [1:0]                    coin_out,
  output logic                          reject,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  // Bit 0 carries the Rs5 line and bit 1 carries the Rs10 line throughout.
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] stable;
  logic [1:0] rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= {coin10_raw, coin5_raw};
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic       stable_q;
    logic [7:0] cnt;

    assign stable[i] = stable_q;
    assign rise[i]   = sync_b[i] & ~stable_q & (cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stable_q <= 1'b0;
        cnt      <= 8'd0;
      end else if (sync_b[i] == stable_q) begin
        cnt <= 8'd0;
      end else if (cnt == DB_LAST) begin
        stable_q <= sync_b[i];
        cnt      <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Classification uses the other line's pre-edge stable value.
  logic       accept;
  logic       rej_now;
  logic [1:0] ev_code;

  always_comb begin
    accept  = 1'b0;
    rej_now = 1'b0;
    ev_code = 2'b00;
    if (rise == 2'b11) begin
      rej_now = 1'b1;
    end else if (rise[0]) begin
      if (stable[1]) rej_now = 1'b1;
      else begin
        accept  = 1'b1;
        ev_code = 2'b01;
      end
    end else if (rise[1]) begin
      if (stable[0]) rej_now = 1'b1;
      else begin
        accept  = 1'b1;
        ev_code = 2'b10;
      end
    end
  end

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  state_t      state;
  logic [3:0]  gap_cnt;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [1:0]  mem [FIFO_DEPTH];
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;

  assign fifo_level = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign pop        = (state == IDLE) & ~empty;
  assign push       = accept & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      reject   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      reject   <= rej_now;
      overflow <= accept & full & ~pop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      coin_out <= 2'b00;
      gap_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            coin_out <= mem[rd_ptr[AW-1:0]];
            state    <= EMIT;
          end
        end
        EMIT: begin
          coin_out <= 2'b00;
          gap_cnt  <= 4'd0;
          state    <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 4'd1;
        end
        default: begin
          coin_out <= 2'b00;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner: a per-cycle reference model plus hand-computed expectations.
module tb_coin_input_conditioner;

  localparam int DEB   = 4;
  localparam int GAP   = 15;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin5_raw;
  logic       coin10_raw;
  logic [1:0] coin_out;
  logic       reject;
  logic       overflow;
  logic [2:0] fifo_level;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin5_raw (coin5_raw),
    .coin10_raw(coin10_raw),
    .coin_out  (coin_out),
    .reject    (reject),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model, evaluated on every rising edge.
  int         cyc = 0;
  bit         m5a, m5b, m10a, m10b;
  bit         st5, st10;
  int         run5, run10;
  logic [1:0] q[$];
  int         next_pop = 0;
  logic [1:0] exp_code = 2'b00;
  bit         exp_rej = 1'b0;
  bit         exp_ovf = 1'b0;
  int         exp_level = 0;
  int         rise5_edge = -1;
  bit         prev5 = 1'b0;

  always @(posedge clk) begin : model
    bit y5, y10, o5, o10, r5, r10, acc, rej, pop, full;
    logic [1:0] code;
    cyc++;
    if (rst && coin5_raw && !prev5) rise5_edge = cyc;
    prev5 = coin5_raw;
    if (!rst) begin
      m5a = 0; m5b = 0; m10a = 0; m10b = 0;
      st5 = 0; st10 = 0; run5 = 0; run10 = 0;
      q.delete();
      next_pop = 0;
      exp_code = 2'b00; exp_rej = 0; exp_ovf = 0; exp_level = 0;
    end else begin
      y5 = m5b; y10 = m10b;
      m5b = m5a; m10b = m10a;
      m5a = coin5_raw; m10a = coin10_raw;
      o5 = st5; o10 = st10;
      r5 = 0; r10 = 0;
      // A line flips after DEB consecutive differing synchronised samples.
      if (y5 != st5) begin
        run5++;
        if (run5 == DEB) begin st5 = y5; run5 = 0; r5 = y5; end
      end else run5 = 0;
      if (y10 != st10) begin
        run10++;
        if (run10 == DEB) begin st10 = y10; run10 = 0; r10 = y10; end
      end else run10 = 0;
      acc = 0; rej = 0; code = 2'b00;
      if (r5 && r10) rej = 1;
      else if (r5)  begin if (o10) rej = 1; else begin acc = 1; code = 2'b01; end end
      else if (r10) begin if (o5)  rej = 1; else begin acc = 1; code = 2'b10; end end
      full = (q.size() == DEPTH);
      pop  = (q.size() > 0) && (cyc >= next_pop);
      if (pop) begin
        exp_code = q.pop_front();
        next_pop = cyc + GAP + 2;
      end else exp_code = 2'b00;
      if (acc && (!full || pop)) q.push_back(code);
      exp_ovf   = acc && full && !pop;
      exp_rej   = rej;
      exp_level = q.size();
    end
  end

  int         n_emit = 0;
  int         n_rej = 0;
  int         n_ovf = 0;
  int         last_emit = -1;
  int         prev_level = 0;
  logic [1:0] emitted[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_coin_out", coin_out, 0);
      chk("rst_reject", reject, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_fifo_level", fifo_level, 0);
      last_emit = -1;
    end else begin
      chk("coin_out", coin_out, exp_code);
      chk("reject", reject, exp_rej);
      chk("overflow", overflow, exp_ovf);
      chk("fifo_level", fifo_level, exp_level);
      if (coin_out != 2'b00) begin
        if (last_emit >= 0) chk("emit_gap_ok", (cyc - last_emit) >= GAP + 2, 1);
        n_emit++;
        emitted.push_back(coin_out);
        last_emit = cyc;
      end
      if (reject) n_rej++;
      if (overflow) begin
        n_ovf++;
        chk("ovf_level_was_full", prev_level, DEPTH);
      end
    end
    prev_level = fifo_level;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic coin(input bit ten, input int hi, input int lo);
    if (ten) coin10_raw = 1'b1;
    else coin5_raw = 1'b1;
    tick(hi);
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    tick(lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int b_emit, b_rej, b_ovf, b_idx;
    bit found;
    rst = 1'b0; coin5_raw = 1'b0; coin10_raw = 1'b0;

    // Reset held while the lines toggle.
    tick(1);
    for (int i = 0; i < 12; i++) begin
      coin5_raw  = 1'($urandom_range(0, 1));
      coin10_raw = 1'($urandom_range(0, 1));
      tick(1);
    end
    coin5_raw = 1'b0; coin10_raw = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(20);
    chk("t1_quiet_no_emit", n_emit, 0);

    // Single Rs5 coin.
    b_emit = n_emit; b_rej = n_rej; b_ovf = n_ovf;
    coin(0, 10, 30);
    chk("t2_one_emit", n_emit - b_emit, 1);
    chk("t2_code", emitted[$], 2'b01);
    chk("t2_latency", last_emit, rise5_edge + DEB + 2);
    chk("t2_level_zero", fifo_level, 0);
    chk("t2_no_reject", n_rej - b_rej, 0);
    chk("t2_no_overflow", n_ovf - b_ovf, 0);

    // Glitches on Rs10: a 3-cycle pulse, then a dropout inside a longer insert.
    b_emit = n_emit;
    coin(1, 3, 10);
    chk("t3_short_pulse_ignored", n_emit - b_emit, 0);
    coin10_raw = 1'b1; tick(3);
    coin10_raw = 1'b0; tick(1);
    coin(1, 6, 30);
    chk("t3_one_emit", n_emit - b_emit, 1);
    chk("t3_code", emitted[$], 2'b10);

    // Ambiguous inserts.
    b_emit = n_emit; b_rej = n_rej;
    coin5_raw = 1'b1; coin10_raw = 1'b1; tick(10);
    coin10_raw = 1'b0; tick(10);
    coin10_raw = 1'b1; tick(10);
    coin5_raw = 1'b0; coin10_raw = 1'b0; tick(30);
    chk("t4_two_rejects", n_rej - b_rej, 2);
    chk("t4_no_emit", n_emit - b_emit, 0);

    // Six alternating coins, 5 high / 5 low.
    b_emit = n_emit; b_ovf = n_ovf; b_idx = emitted.size();
    for (int i = 0; i < 6; i++) coin(i % 2 == 1, 5, 5);
    tick(150);
    chk("t5_emit_plus_ovf", (n_emit - b_emit) + (n_ovf - b_ovf), 6);
    chk("t5_no_overflow", n_ovf - b_ovf, 0);
    for (int i = 0; i < 6 && (b_idx + i) < emitted.size(); i++)
      chk("t5_order", emitted[b_idx + i], (i % 2 == 1) ? 2'b10 : 2'b01);

    // Ten alternating coins, 4 high / 4 low: the ninth is dropped.
    b_emit = n_emit; b_ovf = n_ovf;
    for (int i = 0; i < 10; i++) coin(i % 2 == 1, 4, 4);
    tick(150);
    chk("t5b_emit_plus_ovf", (n_emit - b_emit) + (n_ovf - b_ovf), 10);
    chk("t5b_one_overflow", n_ovf - b_ovf, 1);

    // Reset while three coins are queued and one is on the output.
    for (int i = 0; i < 7; i++) coin(i % 2 == 1, 4, 4);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (coin_out != 2'b00 && fifo_level == 3'd3) found = 1'b1;
    end
    chk("t6_reached_level3_emit", found, 1);
    #1 rst = 1'b0;
    #1;
    if (found) begin
      chk("t6_async_coin_out", coin_out, 0);
      chk("t6_async_level", fifo_level, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    b_emit = n_emit;
    tick(100);
    chk("t6_no_codes_after_reset", n_emit - b_emit, 0);
    chk("t6_level_zero", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
